// File: rtl/alu_operand_seq.sv
// Operand sequencer for the 8-bit ALU subtractor.
// Collects two operands from a valid/ready byte stream and drives them to the subtractor.
// Registers the result with status flags and offers it downstream.
// Only one operation is in flight at a time.
module alu_operand_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] data0_o,
    output logic [WIDTH-1:0] data1_o,
    input  logic [WIDTH-1:0] sub_result_i,
    output logic [WIDTH-1:0] res_data_o,
    output logic             res_borrow_o,
    output logic             res_ovf_o,
    output logic             res_zero_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [CNT_W-1:0] op_count_o
);

    typedef enum logic [1:0] {
        StLoadA,
        StLoadB,
        StExec,
        StOut
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] data0_q, data0_d;
    logic [WIDTH-1:0] data1_q, data1_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             res_valid_q, res_valid_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic in_ready;
    logic in_hs;
    logic out_hs;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StLoadA;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLoadA: if (in_hs)  state_d = StLoadB;
            StLoadB: if (in_hs)  state_d = StExec;
            StExec:              state_d = StOut;
            StOut:   if (out_hs) state_d = StLoadA;
            default:             state_d = StLoadA;
        endcase
    end

    // FSM outputs: ready depends only on state, never on res_ready_i
    always_comb begin
        in_ready = (state_q == StLoadA) || (state_q == StLoadB);
        in_hs    = in_ready && in_valid_i;
        out_hs   = (state_q == StOut) && res_valid_q && res_ready_i;
    end

    // Datapath next-state: operand latches, result capture and completion counter
    always_comb begin
        data0_d     = data0_q;
        data1_d     = data1_q;
        res_data_d  = res_data_q;
        borrow_d    = borrow_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        res_valid_d = res_valid_q;
        op_count_d  = op_count_q;
        if (in_hs && (state_q == StLoadA)) begin
            data0_d = in_data_i;
        end
        if (in_hs && (state_q == StLoadB)) begin
            data1_d = in_data_i;
        end
        if (state_q == StExec) begin
            res_data_d  = sub_result_i;
            borrow_d    = data0_q < data1_q;
            zero_d      = sub_result_i == '0;
            // Signed overflow: operands differ in sign and result sign differs from minuend
            ovf_d       = (data0_q[WIDTH-1] != data1_q[WIDTH-1]) &&
                          (sub_result_i[WIDTH-1] != data0_q[WIDTH-1]);
            res_valid_d = 1'b1;
        end
        if (out_hs) begin
            res_valid_d = 1'b0;
            op_count_d  = op_count_q + 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data0_q     <= '0;
            data1_q     <= '0;
            res_data_q  <= '0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            res_valid_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            data0_q     <= data0_d;
            data1_q     <= data1_d;
            res_data_q  <= res_data_d;
            borrow_q    <= borrow_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            res_valid_q <= res_valid_d;
            op_count_q  <= op_count_d;
        end
    end

    assign in_ready_o   = in_ready;
    assign data0_o      = data0_q;
    assign data1_o      = data1_q;
    assign res_data_o   = res_data_q;
    assign res_borrow_o = borrow_q;
    assign res_ovf_o    = ovf_q;
    assign res_zero_o   = zero_q;
    assign res_valid_o  = res_valid_q;
    assign op_count_o   = op_count_q;

endmodule
